// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
// Bundles the two handshakes of the ALU issue stage into one interface.
//   in_*  : ID stage -> issue stage (instruction, pc, register-file read data)
//   out_* : issue stage -> EX stage (ALU operation and operands)
// Modports:
//   master : the issue stage itself (consumes in_*, produces out_*)
//   slave  : the surrounding pipeline (produces in_*, consumes out_*)
// Parameter XLEN is the operand width; only 32 is supported.
interface alu_issue_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_aluop;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [4:0]      out_rd;
    logic            out_wb;
    logic            out_illegal;

    modport master (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_aluop, out_a, out_b, out_rd, out_wb, out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_aluop, out_a, out_b, out_rd, out_wb, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decodes one RV32I instruction plus its register-file read data into
// {aluop, a, b, rd, wb, illegal} and registers the result behind a 2-entry
// valid/ready skid buffer feeding the combinational ALU in EX.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous flush: drops both entries and any same-cycle input
//   bus       alu_issue_stage_if.master (in_* handshake from ID, out_* to EX)
//   issue_cnt accepted out transfers        (only with ISSUE_CNT_EN)
//   stall_cnt cycles out_valid && !out_ready (only with ISSUE_CNT_EN)
// Optional feature macro: ISSUE_CNT_EN adds the two wrapping counters.
// ALU op codes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//               A BEQ B BNE C BLT D BLTU E BGE F BGEU
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_stage_if.master  bus
`ifdef ISSUE_CNT_EN
    ,
    output logic [CNT_W-1:0]   issue_cnt,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // entry layout: {illegal, wb, rd[4:0], aluop[3:0], a, b}
    localparam int ENT_W = 2 + 5 + 4 + 2 * XLEN;

    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [XLEN-1:0]  imm_i, imm_s, imm_u;
    logic             unused_rs_fields;

    logic [3:0]       dec_aluop;
    logic [XLEN-1:0]  dec_a, dec_b;
    logic [4:0]       dec_rd;
    logic             dec_wb, dec_illegal;
    logic [ENT_W-1:0] dec_entry;

    logic [1:0]       state, state_nxt;
    logic [ENT_W-1:0] out_ent, skid_ent;
    logic             out_valid_r, in_ready_r;
    logic             in_acc, out_acc;
    logic             load_out_new, load_out_skid, load_skid;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    // register indices are consumed by the register file, not here
    assign unused_rs_fields = ^instr[19:15];

    // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA where it applies
    function automatic logic [3:0] arith_op(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  arith_op = alt ? 4'h1 : 4'h0;
            3'b001:  arith_op = 4'h5;
            3'b010:  arith_op = 4'h8;
            3'b011:  arith_op = 4'h9;
            3'b100:  arith_op = 4'h4;
            3'b101:  arith_op = alt ? 4'h7 : 4'h6;
            3'b110:  arith_op = 4'h3;
            default: arith_op = 4'h2;
        endcase
    endfunction

    // Instruction decode; an illegal encoding collapses to an all-zero bubble
    always_comb begin
        dec_aluop   = 4'h0;
        dec_a       = '0;
        dec_b       = '0;
        dec_rd      = instr[11:7];
        dec_wb      = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f7 != 7'h00 && f7 != 7'h20) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_a     = bus.in_rs1_data;
                    dec_b     = bus.in_rs2_data;
                    dec_aluop = arith_op(f3, f7[5]);
                    dec_wb    = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // no SUBI: funct7[5] only matters for the right shift
                dec_a     = bus.in_rs1_data;
                dec_b     = imm_i;
                dec_aluop = arith_op(f3, f7[5] && (f3 == 3'b101));
                dec_wb    = 1'b1;
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = bus.in_pc;
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a  = bus.in_pc;
                dec_b  = XLEN'(4);
                dec_wb = 1'b1;
            end
            OPC_LOAD: begin
                dec_a  = bus.in_rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
            end
            OPC_STORE: begin
                dec_a = bus.in_rs1_data;
                dec_b = imm_s;
            end
            OPC_BRANCH: begin
                dec_a = bus.in_rs1_data;
                dec_b = bus.in_rs2_data;
                case (f3)
                    3'b000:  dec_aluop = 4'hA;
                    3'b001:  dec_aluop = 4'hB;
                    3'b100:  dec_aluop = 4'hC;
                    3'b101:  dec_aluop = 4'hE;
                    3'b110:  dec_aluop = 4'hD;
                    3'b111:  dec_aluop = 4'hF;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_aluop = 4'h0;
            dec_a     = '0;
            dec_b     = '0;
            dec_rd    = 5'd0;
            dec_wb    = 1'b0;
        end
    end

    assign dec_entry = {dec_illegal, dec_wb, dec_rd, dec_aluop, dec_a, dec_b};

    assign in_acc  = bus.in_valid && in_ready_r;
    assign out_acc = out_valid_r && bus.out_ready;

    // Occupancy FSM: out_ent is the head, skid_ent holds the second entry
    always_comb begin
        state_nxt     = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_acc) begin
                    state_nxt    = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_acc && out_acc) begin
                    load_out_new = 1'b1;
                end else if (in_acc) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_acc) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_acc) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt     = ST_EMPTY;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // valid/ready are registered from the next state so in_ready never
    // depends combinationally on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state       <= state_nxt;
            out_valid_r <= (state_nxt != ST_EMPTY);
            in_ready_r  <= (state_nxt != ST_FULL);
        end
    end

    // Data registers only move on a load, so a stalled head stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ent  <= '0;
            skid_ent <= '0;
        end else begin
            if (load_out_new) begin
                out_ent <= dec_entry;
            end else if (load_out_skid) begin
                out_ent <= skid_ent;
            end
            if (load_skid) begin
                skid_ent <= dec_entry;
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_illegal = out_ent[ENT_W-1];
    assign bus.out_wb      = out_ent[ENT_W-2];
    assign bus.out_rd      = out_ent[ENT_W-3 -: 5];
    assign bus.out_aluop   = out_ent[2*XLEN +: 4];
    assign bus.out_a       = out_ent[XLEN +: XLEN];
    assign bus.out_b       = out_ent[0 +: XLEN];

`ifdef ISSUE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counters wrap naturally and survive flush; only rst_n clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_acc) begin
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (out_valid_r && !bus.out_ready) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed bench for alu_issue_stage. A queue-based model of the 2-entry
// buffer plus a table-driven decoder predicts every output cycle; literal
// expectations pin key decode and handshake results.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    logic flush;
`ifdef ISSUE_CNT_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus)
`ifdef ISSUE_CNT_EN
        ,
        .issue_cnt(issue_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic        wb;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        model_q[$];
    logic [31:0] model_issue;
    logic [31:0] model_stall;
    int          pass_count = 0;
    int          total_count = 0;

    // Reference decoder written from the instruction-set rules
    function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0] alu_tab [8];
        logic [3:0] br_tab  [8];
        logic [6:0] opc;
        logic [2:0] fn3;
        logic       alt;
        ent_t       e;
        alu_tab = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
        br_tab  = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hE, 4'hD, 4'hF};
        opc = ins[6:0];
        fn3 = ins[14:12];
        alt = ins[30];
        e = '0;
        e.rd = ins[11:7];
        e.wb = 1'b1;
        if (opc == 7'h33 && (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) begin
            e.a = r1; e.b = r2; e.op = alu_tab[fn3];
            if (alt && fn3 == 3'd0) e.op = 4'h1;
            if (alt && fn3 == 3'd5) e.op = 4'h7;
        end else if (opc == 7'h13) begin
            e.a = r1; e.b = 32'($signed(ins[31:20])); e.op = alu_tab[fn3];
            if (alt && fn3 == 3'd5) e.op = 4'h7;
        end else if (opc == 7'h37) begin
            e.b = ins & 32'hFFFF_F000;
        end else if (opc == 7'h17) begin
            e.a = pc; e.b = ins & 32'hFFFF_F000;
        end else if (opc == 7'h6F || opc == 7'h67) begin
            e.a = pc; e.b = 32'd4;
        end else if (opc == 7'h03) begin
            e.a = r1; e.b = 32'($signed(ins[31:20]));
        end else if (opc == 7'h23) begin
            e.a = r1; e.b = 32'($signed({ins[31:25], ins[11:7]})); e.wb = 1'b0;
        end else if (opc == 7'h63 && fn3 != 3'd2 && fn3 != 3'd3) begin
            e.a = r1; e.b = r2; e.op = br_tab[fn3]; e.wb = 1'b0;
        end else begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until the stage takes it
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
        int   waited;
        logic took;
        waited = 0;
        took   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        while (!took && waited < 64) begin
            took = bus.in_ready;
            tick();
            waited++;
        end
        if (!took) begin
            total_count++;
            $display("[TB] FAIL accept_timeout: instr %h never accepted, expected accept within 64 cycles", instr);
        end
        bus.in_valid = 1'b0;
    endtask

    // Model update on each edge, then compare the settled DUT outputs
    always @(posedge clk) begin
        logic pop;
        logic push;
        if (!rst_n) begin
            model_q.delete();
            model_issue = '0;
            model_stall = '0;
        end else begin
            pop  = (model_q.size() > 0) && bus.out_ready;
            push = bus.in_valid && (model_q.size() < 2);
            if (model_q.size() > 0 && !bus.out_ready) model_stall = model_stall + 1;
            if (pop) model_issue = model_issue + 1;
            if (flush) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (push) model_q.push_back(model_decode(bus.in_instr, bus.in_pc,
                                                         bus.in_rs1_data, bus.in_rs2_data));
            end
        end
        #1;
        checkOutput("model_out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
        checkOutput("model_in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            checkOutput("model_aluop", 32'(bus.out_aluop), 32'(model_q[0].op));
            checkOutput("model_a", bus.out_a, model_q[0].a);
            checkOutput("model_b", bus.out_b, model_q[0].b);
            checkOutput("model_rd", 32'(bus.out_rd), 32'(model_q[0].rd));
            checkOutput("model_wb", 32'(bus.out_wb), 32'(model_q[0].wb));
            checkOutput("model_illegal", 32'(bus.out_illegal), 32'(model_q[0].ill));
        end
`ifdef ISSUE_CNT_EN
        checkOutput("model_issue_cnt", issue_cnt, model_issue);
        checkOutput("model_stall_cnt", stall_cnt, model_stall);
`endif
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc       = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.out_ready   = 1'b1;
        repeat (3) tick();

        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_a", bus.out_a, 32'd0);
        checkOutput("reset_out_b", bus.out_b, 32'd0);
        checkOutput("reset_out_fields", {20'd0, bus.out_aluop, bus.out_rd, bus.out_wb, bus.out_illegal}, 32'd0);
`ifdef ISSUE_CNT_EN
        checkOutput("reset_issue_cnt", issue_cnt, 32'd0);
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        $display("[TB] decode vectors");
        applyStimulus(32'h002081B3, 32'h100, 32'd5, 32'd7);
        checkOutput("add_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("add_aluop", 32'(bus.out_aluop), 32'd0);
        checkOutput("add_a", bus.out_a, 32'd5);
        checkOutput("add_b", bus.out_b, 32'd7);
        checkOutput("add_rd", 32'(bus.out_rd), 32'd3);
        checkOutput("add_wb", 32'(bus.out_wb), 32'd1);

        applyStimulus(32'hFFF08293, 32'h104, 32'h10, 32'h0);
        checkOutput("addi_aluop", 32'(bus.out_aluop), 32'd0);
        checkOutput("addi_b", bus.out_b, 32'hFFFF_FFFF);
        checkOutput("addi_rd", 32'(bus.out_rd), 32'd5);

        applyStimulus(32'h4040D193, 32'h108, 32'h8000_0000, 32'h0);
        checkOutput("srai_aluop", 32'(bus.out_aluop), 32'd7);
        checkOutput("srai_shamt", 32'(bus.out_b[4:0]), 32'd4);

        applyStimulus(32'h0020C063, 32'h10C, 32'h1234, 32'h5678);
        checkOutput("blt_aluop", 32'(bus.out_aluop), 32'hC);
        checkOutput("blt_a", bus.out_a, 32'h1234);
        checkOutput("blt_b", bus.out_b, 32'h5678);
        checkOutput("blt_wb", 32'(bus.out_wb), 32'd0);

        applyStimulus(32'h123450B7, 32'h110, 32'h9, 32'h9);
        checkOutput("lui_a", bus.out_a, 32'd0);
        checkOutput("lui_b", bus.out_b, 32'h1234_5000);

        applyStimulus(32'h00001117, 32'h114, 32'h0, 32'h0);
        checkOutput("auipc_a", bus.out_a, 32'h114);
        checkOutput("auipc_b", bus.out_b, 32'h1000);

        applyStimulus(32'h008000EF, 32'h118, 32'h0, 32'h0);
        checkOutput("jal_b", bus.out_b, 32'd4);

        applyStimulus(32'h0020A423, 32'h11C, 32'h400, 32'h77);
        checkOutput("sw_b", bus.out_b, 32'd8);
        checkOutput("sw_wb", 32'(bus.out_wb), 32'd0);

        applyStimulus(32'h40208233, 32'h120, 32'd9, 32'd4);
        checkOutput("sub_aluop", 32'(bus.out_aluop), 32'd1);

        applyStimulus(32'h0020B2B3, 32'h124, 32'd1, 32'd2);
        checkOutput("sltu_aluop", 32'(bus.out_aluop), 32'd9);

        applyStimulus(32'h022081B3, 32'h128, 32'd3, 32'd4);
        checkOutput("mul_illegal", 32'(bus.out_illegal), 32'd1);

        applyStimulus(32'h0000007F, 32'h12C, 32'hAA, 32'hBB);
        checkOutput("ill_flag", 32'(bus.out_illegal), 32'd1);
        checkOutput("ill_aluop", 32'(bus.out_aluop), 32'd0);
        checkOutput("ill_a", bus.out_a, 32'd0);
        checkOutput("ill_b", bus.out_b, 32'd0);
        checkOutput("ill_wb", 32'(bus.out_wb), 32'd0);
        tick();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(32'h002081B3, 32'h200, 32'h11, 32'h1);
        applyStimulus(32'h002081B3, 32'h204, 32'h22, 32'h1);
        checkOutput("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_head_1", bus.out_a, 32'h11);
        bus.in_valid    = 1'b1;
        bus.in_instr    = 32'h002081B3;
        bus.in_pc       = 32'h208;
        bus.in_rs1_data = 32'h33;
        bus.in_rs2_data = 32'h1;
        tick();
        tick();
        checkOutput("bp_head_held", bus.out_a, 32'h11);
        checkOutput("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_head_2", bus.out_a, 32'h22);
        tick();
        checkOutput("bp_head_3", bus.out_a, 32'h33);
        bus.in_valid = 1'b0;
        tick();
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

        $display("[TB] flush while full");
        bus.out_ready = 1'b0;
        applyStimulus(32'h002081B3, 32'h300, 32'h44, 32'h1);
        applyStimulus(32'h002081B3, 32'h304, 32'h55, 32'h1);
        bus.in_valid    = 1'b1;
        bus.in_instr    = 32'h002081B3;
        bus.in_pc       = 32'h308;
        bus.in_rs1_data = 32'h66;
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("flush_no_leak", 32'(bus.out_valid), 32'd0);

        $display("[TB] async reset mid-stall");
        bus.out_ready = 1'b0;
        applyStimulus(32'h002081B3, 32'h400, 32'h77, 32'h1);
        tick();
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("async_rst_a", bus.out_a, 32'd0);
`ifdef ISSUE_CNT_EN
        checkOutput("async_rst_issue", issue_cnt, 32'd0);
        checkOutput("async_rst_stall", stall_cnt, 32'd0);
`endif
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        applyStimulus(32'h002081B3, 32'h500, 32'd20, 32'd22);
        checkOutput("post_rst_a", bus.out_a, 32'd20);
        repeat (2) tick();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
